// File: rtl/buf_loader.sv
// buf_loader: one DMA burst per load pulse; IFM beats written 1:1, filter beats repacked 4B->9B into 4 buffers.
// Latency: cmd at t+1 after pulse, write at t+1 after beat, done at t+2; ready=1 only while bursting.
module buf_loader #(
  parameter int W_SIZE    = 8,
  parameter int W_CHANNEL = 8,
  parameter int IFM_DW    = 32,
  parameter int FILTER_DW = 72,
  parameter int IFM_AW    = 12,
  parameter int FILTER_AW = 8,
  parameter int LEN_W     = 24
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [W_SIZE-1:0]    q_width,
  input  logic [W_SIZE-1:0]    q_height,
  input  logic [W_CHANNEL-1:0] q_channel,
  input  logic [W_CHANNEL-1:0] q_outchn,
  input  logic [31:0]          q_ifm_base,
  input  logic [31:0]          q_filter_base,
  input  logic                 q_load_ifm,
  input  logic                 q_load_filter,
  output logic                 o_load_ifm_done,
  output logic                 o_load_filter_done,
  output logic                 dma_rd_req,
  output logic [31:0]          dma_rd_addr,
  output logic [LEN_W-1:0]     dma_rd_len,
  input  logic                 dma_rd_ack,
  input  logic [31:0]          dma_rd_data,
  input  logic                 dma_rd_valid,
  output logic                 dma_rd_ready,
  output logic                 ifm_buf_ena,
  output logic                 ifm_buf_wea,
  output logic [IFM_AW-1:0]    ifm_buf_addra,
  output logic [IFM_DW-1:0]    ifm_buf_dia,
  output logic [3:0]           fb_wea,
  output logic [FILTER_AW-1:0] fb_addra,
  output logic [FILTER_DW-1:0] fb_dia
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DONE} state_t;

  state_t               state, nxt;
  logic                 pend_ifm, pend_flt;
  logic                 is_flt;
  logic                 take_ifm, take_flt;
  logic [LEN_W-1:0]     beat_cnt;
  logic [W_CHANNEL-1:0] k_reg;
  logic [W_CHANNEL-1:0] a_cnt;
  logic [1:0]           f_cnt;
  logic [3:0]           gb_cnt;
  logic [95:0]          acc;
  logic [95:0]          full;
  logic                 emit;
  logic                 beat_acc;
  logic [LEN_W-1:0]     ifm_len, flt_len;
  logic [31:0]          flt_addr;

  assign beat_acc = dma_rd_valid & dma_rd_ready;
  assign ifm_len  = LEN_W'(q_width) * LEN_W'(q_height) * LEN_W'(q_channel);
  assign flt_len  = LEN_W'(q_channel) * LEN_W'(9);
  assign flt_addr = q_filter_base + 32'(q_outchn) * 32'(q_channel) * 32'd36;

  // New beat lands just above the bytes already held; 9 or more bytes yields one word.
  assign full = acc | ({64'b0, dma_rd_data} << {gb_cnt, 3'b000});
  assign emit = (gb_cnt >= 4'd5);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt      = state;
    take_ifm = 1'b0;
    take_flt = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_ifm || q_load_ifm) begin
          take_ifm = 1'b1;
          nxt      = (ifm_len == '0) ? S_DONE : S_REQ;
        end else if (pend_flt || q_load_filter) begin
          take_flt = 1'b1;
          nxt      = (flt_len == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ:  if (dma_rd_ack) nxt = S_DATA;
      S_DATA: if (beat_acc && beat_cnt == dma_rd_len - LEN_W'(1)) nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_ifm           <= 1'b0;
      pend_flt           <= 1'b0;
      is_flt             <= 1'b0;
      beat_cnt           <= '0;
      k_reg              <= '0;
      a_cnt              <= '0;
      f_cnt              <= '0;
      gb_cnt             <= '0;
      acc                <= '0;
      o_load_ifm_done    <= 1'b0;
      o_load_filter_done <= 1'b0;
      dma_rd_req         <= 1'b0;
      dma_rd_addr        <= '0;
      dma_rd_len         <= '0;
      dma_rd_ready       <= 1'b0;
      ifm_buf_ena        <= 1'b0;
      ifm_buf_wea        <= 1'b0;
      ifm_buf_addra      <= '0;
      ifm_buf_dia        <= '0;
      fb_wea             <= '0;
      fb_addra           <= '0;
      fb_dia             <= '0;
    end else begin
      // A pulse coincident with its own service is consumed, not re-queued.
      pend_ifm           <= (pend_ifm | q_load_ifm) & ~take_ifm;
      pend_flt           <= (pend_flt | q_load_filter) & ~take_flt;
      dma_rd_req         <= (nxt == S_REQ);
      dma_rd_ready       <= (nxt == S_DATA);
      o_load_ifm_done    <= (state == S_DONE) && !is_flt;
      o_load_filter_done <= (state == S_DONE) && is_flt;
      ifm_buf_ena        <= beat_acc && !is_flt;
      ifm_buf_wea        <= beat_acc && !is_flt;
      fb_wea             <= '0;

      if (take_ifm || take_flt) begin
        is_flt      <= take_flt;
        dma_rd_len  <= take_flt ? flt_len : ifm_len;
        dma_rd_addr <= take_flt ? flt_addr : q_ifm_base;
        k_reg       <= q_channel;
        beat_cnt    <= '0;
        a_cnt       <= '0;
        f_cnt       <= '0;
        gb_cnt      <= '0;
        acc         <= '0;
      end

      if (beat_acc) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
        if (!is_flt) begin
          ifm_buf_addra <= beat_cnt[IFM_AW-1:0];
          ifm_buf_dia   <= IFM_DW'(dma_rd_data);
        end else if (emit) begin
          acc      <= full >> 72;
          gb_cnt   <= gb_cnt - 4'd5;
          fb_wea   <= 4'b0001 << f_cnt;
          fb_addra <= FILTER_AW'(a_cnt);
          fb_dia   <= FILTER_DW'(full[71:0]);
          if (a_cnt == k_reg - W_CHANNEL'(1)) begin
            a_cnt <= '0;
            f_cnt <= f_cnt + 2'd1;
          end else begin
            a_cnt <= a_cnt + W_CHANNEL'(1);
          end
        end else begin
          acc    <= full;
          gb_cnt <= gb_cnt + 4'd4;
        end
      end
    end
  end

endmodule

// File: tb/tb_buf_loader.sv
// Directed bench for buf_loader: DMA responder, write monitor, expectations built from the byte stream.
module tb_buf_loader;
  localparam int W_SIZE = 8, W_CHANNEL = 8, IFM_DW = 32, FILTER_DW = 72;
  localparam int IFM_AW = 12, FILTER_AW = 8, LEN_W = 24;

  logic clk, rstn;
  logic [W_SIZE-1:0] q_width, q_height;
  logic [W_CHANNEL-1:0] q_channel, q_outchn;
  logic [31:0] q_ifm_base, q_filter_base;
  logic q_load_ifm, q_load_filter;
  logic o_load_ifm_done, o_load_filter_done;
  logic dma_rd_req, dma_rd_ack, dma_rd_valid, dma_rd_ready;
  logic [31:0] dma_rd_addr, dma_rd_data;
  logic [LEN_W-1:0] dma_rd_len;
  logic ifm_buf_ena, ifm_buf_wea;
  logic [IFM_AW-1:0] ifm_buf_addra;
  logic [IFM_DW-1:0] ifm_buf_dia;
  logic [3:0] fb_wea;
  logic [FILTER_AW-1:0] fb_addra;
  logic [FILTER_DW-1:0] fb_dia;

  buf_loader #(.W_SIZE(W_SIZE), .W_CHANNEL(W_CHANNEL), .IFM_DW(IFM_DW), .FILTER_DW(FILTER_DW),
               .IFM_AW(IFM_AW), .FILTER_AW(FILTER_AW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn), .q_width(q_width), .q_height(q_height), .q_channel(q_channel),
    .q_outchn(q_outchn), .q_ifm_base(q_ifm_base), .q_filter_base(q_filter_base),
    .q_load_ifm(q_load_ifm), .q_load_filter(q_load_filter),
    .o_load_ifm_done(o_load_ifm_done), .o_load_filter_done(o_load_filter_done),
    .dma_rd_req(dma_rd_req), .dma_rd_addr(dma_rd_addr), .dma_rd_len(dma_rd_len),
    .dma_rd_ack(dma_rd_ack), .dma_rd_data(dma_rd_data), .dma_rd_valid(dma_rd_valid),
    .dma_rd_ready(dma_rd_ready), .ifm_buf_ena(ifm_buf_ena), .ifm_buf_wea(ifm_buf_wea),
    .ifm_buf_addra(ifm_buf_addra), .ifm_buf_dia(ifm_buf_dia),
    .fb_wea(fb_wea), .fb_addra(fb_addra), .fb_dia(fb_dia));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic any_out;
  assign any_out = |{o_load_ifm_done, o_load_filter_done, dma_rd_req, dma_rd_addr, dma_rd_len,
                     dma_rd_ready, ifm_buf_ena, ifm_buf_wea, ifm_buf_addra, ifm_buf_dia,
                     fb_wea, fb_addra, fb_dia};

  // Monitor: log every write strobe, done pulse and request rising edge.
  logic [IFM_AW-1:0] ifm_a [256];
  logic [31:0]       ifm_d [256];
  int                ifm_c [256];
  logic [3:0]        fb_w  [256];
  logic [7:0]        fb_a  [256];
  logic [71:0]       fb_d  [256];
  int ifm_n = 0, fb_n = 0, ifm_done_n = 0, flt_done_n = 0, req_n = 0;
  int ifm_done_cyc = 0, flt_done_cyc = 0;
  logic req_prev = 1'b0;

  always @(negedge clk) begin
    if (ifm_buf_ena && ifm_buf_wea) begin
      if (ifm_n < 256) begin
        ifm_a[ifm_n] = ifm_buf_addra; ifm_d[ifm_n] = ifm_buf_dia; ifm_c[ifm_n] = cyc;
      end
      ifm_n++;
    end
    if (fb_wea != 4'b0) begin
      if (fb_n < 256) begin
        fb_w[fb_n] = fb_wea; fb_a[fb_n] = fb_addra; fb_d[fb_n] = fb_dia;
      end
      fb_n++;
    end
    if (o_load_ifm_done)    begin ifm_done_n++; ifm_done_cyc = cyc; end
    if (o_load_filter_done) begin flt_done_n++; flt_done_cyc = cyc; end
    if (dma_rd_req && !req_prev) req_n++;
    req_prev = dma_rd_req;
  end

  int n_pass = 0, n_chk = 0;
  int last_acc = 0, pc = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [71:0] fword(input int w);
    logic [71:0] r;
    for (int j = 0; j < 9; j++) r[8*j +: 8] = 8'(9*w + j);
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input bit ifm, input bit flt);
    q_load_ifm = ifm; q_load_filter = flt; pc = cyc;
    step(1);
    q_load_ifm = 1'b0; q_load_filter = 1'b0;
  endtask

  // Answers one command and streams nb beats; IFM beats carry their index, filter beats a byte ramp.
  task automatic serve(input logic [31:0] ea, input int el, input int dly, input bit gap,
                       input bit flt, input int nb);
    int t;
    bit stable;
    t = 0;
    while (!dma_rd_req && t < 50) begin step(1); t++; end
    chk("req_seen", 96'(dma_rd_req), 96'(1));
    chk("req_addr", 96'(dma_rd_addr), 96'(ea));
    chk("req_len", 96'(dma_rd_len), 96'(el));
    stable = 1'b1;
    for (int d = 0; d < dly; d++) begin
      step(1);
      if (!(dma_rd_req === 1'b1 && dma_rd_addr === ea && dma_rd_len === LEN_W'(el))) stable = 1'b0;
    end
    chk("req_stable", 96'(stable), 96'(1));
    dma_rd_ack = 1'b1; step(1); dma_rd_ack = 1'b0;
    for (int i = 0; i < nb; i++) begin
      dma_rd_valid = 1'b1;
      dma_rd_data  = flt ? {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)} : 32'(i);
      t = 0;
      while (!dma_rd_ready && t < 50) begin step(1); t++; end
      if (t >= 50) chk("beat_timeout", 96'(t), 96'(0));
      step(1);
      last_acc = cyc;
      if (gap) begin dma_rd_valid = 1'b0; step(1); end
    end
    dma_rd_valid = 1'b0;
  endtask

  task automatic check_filter(input int b);
    chk("flt_nwr", 96'(fb_n - b), 96'(8));
    for (int w = 0; w < 8; w++) begin
      chk("flt_wea", 96'(fb_w[b+w]), 96'(4'b0001 << (w/2)));
      chk("flt_addr", 96'(fb_a[b+w]), 96'(w % 2));
      chk("flt_data", 96'(fb_d[b+w]), 96'(fword(w)));
    end
    chk("flt_buf0_a0", 96'(fb_d[b]), 96'(72'h08_0706050403020100));
    chk("flt_buf3_a1", 96'(fb_d[b+7]), 96'(72'h47_464544434241403F));
  endtask

  int b0, b1, d0, d1, r0;

  initial begin
    rstn = 1'b0; q_width = 8'd4; q_height = 8'd2; q_channel = 8'd3; q_outchn = 8'd0;
    q_ifm_base = 32'h1000; q_filter_base = 32'h0; q_load_ifm = 1'b0; q_load_filter = 1'b0;
    dma_rd_ack = 1'b0; dma_rd_data = 32'h0; dma_rd_valid = 1'b0;
    step(3);
    chk("reset_outs", 96'(any_out), 96'(0));
    rstn = 1'b1;
    step(2);
    chk("idle_outs", 96'(any_out), 96'(0));

    // IFM load 4x2x3
    b0 = ifm_n; d0 = ifm_done_n;
    pulse(1'b1, 1'b0);
    chk("req_lat", 96'(dma_rd_req), 96'(1));
    serve(32'h1000, 24, 0, 1'b0, 1'b0, 24);
    step(5);
    chk("ifm_nwr", 96'(ifm_n - b0), 96'(24));
    for (int i = 0; i < 24; i++) begin
      chk("ifm_addr", 96'(ifm_a[b0+i]), 96'(i));
      chk("ifm_data", 96'(ifm_d[b0+i]), 96'(i));
    end
    chk("ifm_wr_lat", 96'(ifm_c[b0+23]), 96'(last_acc));
    chk("ifm_done_n", 96'(ifm_done_n - d0), 96'(1));
    chk("ifm_done_lat", 96'(ifm_done_cyc), 96'(last_acc + 1));

    // Filter load K=2, group 1
    q_channel = 8'd2; q_outchn = 8'd1; q_filter_base = 32'h0;
    b1 = fb_n; d1 = flt_done_n;
    pulse(1'b0, 1'b1);
    serve(32'd72, 18, 0, 1'b0, 1'b1, 18);
    step(5);
    check_filter(b1);
    chk("flt_done_n", 96'(flt_done_n - d1), 96'(1));
    chk("flt_done_lat", 96'(flt_done_cyc), 96'(last_acc + 1));

    // Same filter load with valid gaps and a delayed ack
    b1 = fb_n;
    pulse(1'b0, 1'b1);
    serve(32'd72, 18, 5, 1'b1, 1'b1, 18);
    step(5);
    check_filter(b1);

    // Simultaneous pulses: IFM first, then filter without re-pulse
    q_channel = 8'd3; q_outchn = 8'd1;
    d0 = ifm_done_n; d1 = flt_done_n; b1 = fb_n;
    pulse(1'b1, 1'b1);
    serve(32'h1000, 24, 0, 1'b0, 1'b0, 24);
    step(2);
    chk("sim_ifm_done", 96'(ifm_done_n - d0), 96'(1));
    chk("sim_flt_not_yet", 96'(flt_done_n - d1), 96'(0));
    serve(32'd108, 27, 0, 1'b0, 1'b1, 27);
    step(5);
    chk("sim_flt_done", 96'(flt_done_n - d1), 96'(1));
    chk("sim_ifm_once", 96'(ifm_done_n - d0), 96'(1));
    chk("sim_flt_nwr", 96'(fb_n - b1), 96'(12));
    chk("sim_order", 96'(flt_done_cyc > ifm_done_cyc), 96'(1));

    // Zero length
    q_height = 8'd0; r0 = req_n; d0 = ifm_done_n;
    pulse(1'b1, 1'b0);
    step(5);
    chk("zero_no_req", 96'(req_n - r0), 96'(0));
    chk("zero_done_n", 96'(ifm_done_n - d0), 96'(1));
    chk("zero_done_lat", 96'(ifm_done_cyc), 96'(pc + 2));

    // Reset after 10 of 24 beats
    q_height = 8'd2;
    pulse(1'b1, 1'b0);
    serve(32'h1000, 24, 0, 1'b0, 1'b0, 10);
    dma_rd_valid = 1'b1; dma_rd_data = 32'hDEAD_BEEF;
    rstn = 1'b0;
    #1;
    chk("mid_rst_outs", 96'(any_out), 96'(0));
    step(2);
    chk("mid_rst_hold", 96'(any_out), 96'(0));
    chk("mid_rst_ready", 96'(dma_rd_ready), 96'(0));
    dma_rd_valid = 1'b0;
    rstn = 1'b1;
    step(2);
    b0 = ifm_n; r0 = req_n;
    chk("post_rst_noreq", 96'(dma_rd_req), 96'(0));
    pulse(1'b1, 1'b0);
    serve(32'h1000, 24, 0, 1'b0, 1'b0, 24);
    step(5);
    chk("post_rst_nwr", 96'(ifm_n - b0), 96'(24));
    chk("post_rst_addr0", 96'(ifm_a[b0]), 96'(0));
    chk("post_rst_data0", 96'(ifm_d[b0]), 96'(0));
    chk("post_rst_last", 96'(ifm_a[b0+23]), 96'(23));
    chk("post_rst_req", 96'(req_n - r0), 96'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/buf_loader.md
# buf_loader

Upstream fill stage for `buf_manager`. On a `q_load_ifm` or `q_load_filter` pulse it issues one burst read command to the AXI read DMA and accepts the returned 32-bit beat stream. IFM beats are written straight into the IFM buffer write port. Filter beats are repacked through a byte gearbox into 72-bit words and distributed across the four filter buffer write ports. It also generates the `o_load_ifm_done` and `o_load_filter_done` pulses.

## Interface
- W_SIZE, `W_SIZE`: width/height field width
- W_CHANNEL, `W_CHANNEL`: channel field width
- IFM_DW, `IFM_DW` (32): IFM word / DMA beat width
- FILTER_DW, `FILTER_DW` (72): filter word width (9 bytes)
- IFM_AW, `IFM_TOTAL_BUFFER_AW`: IFM buffer address width
- FILTER_AW, `FILTER_BUFFER_AW`: filter buffer address width
- LEN_W, 24: DMA length field width (beats)
- clk  in  1  clock; the only clock
- rstn  in  1  asynchronous, active-low reset
- q_width, q_height  in  W_SIZE  IFM dimensions
- q_channel  in  W_CHANNEL  tiled input channel count (K)
- q_outchn  in  W_CHANNEL  output-channel group index (4 filters per group)
- q_ifm_base, q_filter_base  in  32  DRAM byte base addresses
- q_load_ifm, q_load_filter  in  1  single-cycle start pulses
- o_load_ifm_done, o_load_filter_done  out  1  single-cycle completion pulses
- dma_rd_req  out  1  command valid; held until acked
- dma_rd_addr  out  32  command byte address
- dma_rd_len  out  LEN_W  command length in beats
- dma_rd_ack  in  1  command accepted
- dma_rd_data  in  32  beat data, little-endian bytes
- dma_rd_valid  in  1  beat valid
- dma_rd_ready  out  1  beat ready
- ifm_buf_ena, ifm_buf_wea  out  1  IFM buffer write strobe (both driven together)
- ifm_buf_addra  out  IFM_AW  IFM write address
- ifm_buf_dia  out  IFM_DW  IFM write data
- fb_wea  out  4  one-hot filter buffer select and write strobe
- fb_addra  out  FILTER_AW  filter write address (shared by all four buffers)
- fb_dia  out  FILTER_DW  filter write data (shared by all four buffers)

## Operation
- FSM states: IDLE, REQ, DATA, DONE. A load type is selected in IDLE and latched for the whole load.
- **Pending latches.** `q_load_ifm` and `q_load_filter` pulses set `pend_ifm` and `pend_flt`.
  - A pulse is latched in any state.
  - IDLE services `pend_ifm` first, then `pend_flt`. That pending bit is cleared on the cycle IDLE leaves.
- **IFM load.**
  - Beat count N = q_width·q_height·q_channel, computed in LEN_W bits.
  - `dma_rd_addr` = q_ifm_base.
  - Beat i is written to IFM address i, with the address truncated to IFM_AW bits.
- **Filter load.**
  - Per-filter word count is K = q_channel.
  - Beat count N = 9·K, because 4 filters × K words × 9 bytes = 36K bytes = 9K beats.
  - `dma_rd_addr` = q_filter_base + q_outchn·36·K, computed mod 2^32.
- **Filter gearbox.**
  - A 96-bit byte accumulator holds `cnt` bytes, 0..8 between beats.
  - Each beat appends its 4 bytes above the held bytes; beat byte 0 is bits [7:0].
  - When cnt+4 ≥ 9, the lowest 9 bytes are emitted as one word: the first-received byte goes to fb_dia[7:0]. The remaining cnt−5 bytes shift down.
  - At most one word is emitted per beat.
- **Filter word placement.** Word index w runs 0..4K−1 and is tracked as counters (f, a):
  - f = w / K selects the buffer (`fb_wea` bit f); a = w mod K is `fb_addra`.
  - a wraps to 0 at K−1 and f increments.
  - At load end cnt is exactly 0.
- **REQ.** `dma_rd_req` stays high with addr/len stable until `dma_rd_ack`, then the FSM enters DATA.
- **DATA.**
  - `dma_rd_ready` = 1 throughout DATA and 0 in all other states.
  - A beat is accepted on valid & ready and the beat counter increments.
  - After beat N−1 is accepted the FSM enters DONE.
- **DONE.** Pulses the done output of the latched type for 1 cycle, then returns to IDLE.
- **Zero length.** If N = 0 (any dimension 0), the FSM goes IDLE→DONE and issues no DMA command.
- Beats presented while not in DATA are not accepted (ready = 0).
- **Reset.** rstn low at any time, including mid-burst, forces all of the following to 0, regardless of in-flight DMA beats:
  - state → IDLE
  - pending bits, counters and the accumulator
  - `dma_rd_req`, `dma_rd_ready`, all write strobes, both done pulses, and the addr/data/len outputs

## Timing
- All outputs are registered.
- A command pulse at cycle t (FSM in IDLE) raises `dma_rd_req` at t+1.
- A beat accepted at cycle t produces its IFM write, or the filter write it completes, at t+1.
- Done pulses at t+2 after the last beat is accepted, i.e. 1 cycle after the last write strobe.
- `dma_rd_valid` gaps insert idle cycles; no write occurs in a cycle with no accepted beat.
- Back-to-back loads: IDLE is visited for 1 cycle between DONE and the next REQ.

## Test plan
- **IFM load.** q_width=4, q_height=2, q_channel=3, base 0x1000, beats 0..23 streamed continuously:
  - required: req addr 0x1000, len 24;
  - IFM writes addr 0..23 with data = beat index;
  - exactly one `o_load_ifm_done` pulse, 2 cycles after the last beat.
- **Filter load.** q_channel=2, q_outchn=1, base 0:
  - required: addr 72, len 18;
  - beat bytes 0x00,0x01,… → buf0 addr0 = 0x08_07060504_03020100, buf0 addr1 starts at byte 0x09;
  - buf3 addr1 holds bytes 0x3F..0x47, with 8 writes total.
- **Valid gaps.** Filter load with `dma_rd_valid` toggling every other cycle and ack delayed 5 cycles:
  - required: same data/addresses as the filter-load test;
  - req held stable for 5 cycles before ack.
- **Simultaneous pulses.** q_load_ifm and q_load_filter in the same cycle:
  - IFM load completes first, then the filter load starts with no re-pulse;
  - each done pulses once.
- **Zero length.** q_height=0 with q_load_ifm:
  - no `dma_rd_req`;
  - `o_load_ifm_done` 2 cycles after the pulse.
- **Reset mid-burst.** rstn asserted after 10 of 24 IFM beats:
  - all outputs 0 and ready 0 during reset;
  - after release a fresh q_load_ifm restarts at IFM address 0.
